// File: rtl/video_frame_capture.sv
// rtl/video_frame_capture.sv - captures a synced pixel stream into length-tagged SDRAM write bursts
//
// Purpose: registers the V_SYNC/BLANK/display_data stream, buffers active
// pixels in a show-ahead FIFO and hands them to the SDRAM write port as
// bursts inside a wrapping [wr_addr_min, wr_addr_max) region.
//
// Ports:
//   clk_rd, rst                  clock, asynchronous active-high reset
//   capture_en, ping_pong_en     arm capture / toggle wr_bank per frame
//   wr_addr_min, wr_addr_max     frame region (max exclusive)
//   br_length                    maximum burst length (0 behaves as 1)
//   H_SYNC, V_SYNC, BLANK        input timing (BLANK high = active pixel)
//   display_data                 input pixel
//   wr_req/wr_ack                burst request / one-cycle grant
//   wr_addr, wr_len, wr_bank     burst descriptor
//   wr_data, wr_data_rd          FIFO head and pop strobe
//   frame_done                   one-cycle pulse once a frame is flushed
//   overflow, fmt_err            sticky error flags
//   fifo_level                   FIFO occupancy
module video_frame_capture #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic        clk_rd,
  input  logic        rst,
  input  logic        capture_en,
  input  logic        ping_pong_en,
  input  logic [23:0] wr_addr_min,
  input  logic [23:0] wr_addr_max,
  input  logic [9:0]  br_length,
  input  logic        H_SYNC,
  input  logic        V_SYNC,
  input  logic        BLANK,
  input  logic [15:0] display_data,
  output logic        wr_req,
  input  logic        wr_ack,
  output logic [23:0] wr_addr,
  output logic [9:0]  wr_len,
  output logic        wr_bank,
  output logic [15:0] wr_data,
  input  logic        wr_data_rd,
  output logic        frame_done,
  output logic        overflow,
  output logic        fmt_err,
  output logic [10:0] fifo_level
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] H_LEN    = 16'(H_ACTIVE);
  localparam logic [15:0] V_LEN    = 16'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t      state_q, state_d;
  logic        vs_q, vs_prev_q, blank_q, blank_prev_q;
  logic [15:0] pix_q;
  logic        capturing_q, capturing_d;
  logic        flush_q, flush_d;
  logic        init_q, init_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        ovf_q, ovf_d, fmt_q, fmt_d;
  logic        bank_q, bank_d, done_q, done_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [23:0] ptr_q, ptr_d;
  logic [9:0]  len_q, len_d, cnt_q, cnt_d;

  logic [15:0] mem [FIFO_DEPTH];

  logic [AW:0] level;
  logic        full, pix_valid, push, pop;
  logic        frame_start, frame_end, line_end;
  logic [9:0]  burst_max;
  logic [23:0] space, level_ext, burst_ext, next_ptr;
  logic [15:0] y_line;
  logic        unused_hsync;

  assign unused_hsync = H_SYNC;

  assign level     = wptr_q - rptr_q;
  assign full      = (level == FULL_LVL);
  assign pix_valid = capturing_q & blank_q;
  assign push      = pix_valid & ~full;
  // Pops are only honoured inside a granted burst; the burst FSM leaves XFER
  // after wr_len pops, so extra strobes fall on the floor.
  assign pop       = (state_q == XFER) & wr_data_rd & (level != '0);

  assign burst_max = (br_length == 10'd0) ? 10'd1 : br_length;
  assign space     = wr_addr_max - ptr_q;
  assign level_ext = 24'(level);
  assign burst_ext = 24'(burst_max);
  assign next_ptr  = ptr_q + 24'(len_q);

  assign frame_start = vs_q & ~vs_prev_q;
  assign frame_end   = vs_prev_q & ~vs_q & capturing_q;
  assign line_end    = blank_prev_q & ~blank_q & capturing_q;
  // Line count including a line that closes in the same cycle as the frame.
  assign y_line      = line_end ? (y_q + 16'd1) : y_q;

  always_comb begin
    state_d     = state_q;
    capturing_d = capturing_q;
    flush_d     = flush_q;
    init_d      = init_q;
    x_d         = x_q;
    y_d         = y_q;
    ovf_d       = ovf_q | (pix_valid & full);
    fmt_d       = fmt_q;
    bank_d      = bank_q;
    done_d      = 1'b0;
    wptr_d      = wptr_q + (AW+1)'(push);
    rptr_d      = rptr_q + (AW+1)'(pop);
    ptr_d       = ptr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;

    // The region base is picked up on the first cycle out of reset.
    if (!init_q) begin
      init_d = 1'b1;
      ptr_d  = wr_addr_min;
    end

    if (pix_valid) x_d = x_q + 16'd1;

    if (line_end) begin
      if (x_q != H_LEN) fmt_d = 1'b1;
      x_d = 16'd0;
      y_d = y_line;
    end

    if (frame_end) begin
      if (y_line != V_LEN) fmt_d = 1'b1;
      capturing_d = 1'b0;
      flush_d     = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (level_ext >= burst_ext) begin
          state_d = REQ;
          len_d   = (space < burst_ext) ? space[9:0] : burst_max;
        end else if (flush_q && (level != '0)) begin
          // Tail of the frame: send whatever is left as a short burst.
          state_d = REQ;
          len_d   = (space < level_ext) ? space[9:0] : level_ext[9:0];
        end else if (flush_q) begin
          done_d  = 1'b1;
          flush_d = 1'b0;
          if (ping_pong_en) bank_d = ~bank_q;
        end
      end
      REQ: begin
        if (wr_ack) begin
          state_d = XFER;
          cnt_d   = 10'd0;
        end
      end
      XFER: begin
        if (pop) begin
          cnt_d = cnt_q + 10'd1;
          if (cnt_q + 10'd1 == len_q) begin
            state_d = IDLE;
            ptr_d   = (next_ptr >= wr_addr_max) ? wr_addr_min : next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new frame can only start once the previous one is fully flushed, so
    // the burst FSM is idle here and restarting the pointer is safe.
    if (frame_start && capture_en && !flush_q) begin
      capturing_d = 1'b1;
      x_d         = 16'd0;
      y_d         = 16'd0;
      ptr_d       = wr_addr_min;
    end
  end

  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vs_q         <= 1'b0;
      vs_prev_q    <= 1'b0;
      blank_q      <= 1'b0;
      blank_prev_q <= 1'b0;
      pix_q        <= 16'd0;
      capturing_q  <= 1'b0;
      flush_q      <= 1'b0;
      init_q       <= 1'b0;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      ovf_q        <= 1'b0;
      fmt_q        <= 1'b0;
      bank_q       <= 1'b0;
      done_q       <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      ptr_q        <= 24'd0;
      len_q        <= 10'd0;
      cnt_q        <= 10'd0;
    end else begin
      state_q      <= state_d;
      vs_q         <= V_SYNC;
      vs_prev_q    <= vs_q;
      blank_q      <= BLANK;
      blank_prev_q <= blank_q;
      pix_q        <= display_data;
      capturing_q  <= capturing_d;
      flush_q      <= flush_d;
      init_q       <= init_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ovf_q        <= ovf_d;
      fmt_q        <= fmt_d;
      bank_q       <= bank_d;
      done_q       <= done_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      ptr_q        <= ptr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk_rd) begin
    if (push) mem[wptr_q[AW-1:0]] <= pix_q;
  end

  assign wr_req     = (state_q == REQ);
  assign wr_addr    = ptr_q;
  assign wr_len     = len_q;
  assign wr_bank    = bank_q;
  assign wr_data    = (level != '0) ? mem[rptr_q[AW-1:0]] : 16'd0;
  assign frame_done = done_q;
  assign overflow   = ovf_q;
  assign fmt_err    = fmt_q;
  assign fifo_level = 11'(level);

endmodule

// File: tb/tb_video_frame_capture.sv
// tb/tb_video_frame_capture.sv - directed self-checking bench for video_frame_capture
module tb_video_frame_capture;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int FD = 16;

  logic        clk_rd = 1'b0;
  logic        rst = 1'b1;
  logic        capture_en = 1'b1;
  logic        ping_pong_en = 1'b1;
  logic [23:0] wr_addr_min = 24'd0;
  logic [23:0] wr_addr_max = 24'd1000;
  logic [9:0]  br_length = 10'd8;
  logic        H_SYNC = 1'b0;
  logic        V_SYNC = 1'b0;
  logic        BLANK = 1'b0;
  logic [15:0] display_data = 16'd0;
  logic        wr_req;
  logic        wr_ack;
  logic [23:0] wr_addr;
  logic [9:0]  wr_len;
  logic        wr_bank;
  logic [15:0] wr_data;
  logic        wr_data_rd;
  logic        frame_done;
  logic        overflow;
  logic        fmt_err;
  logic [10:0] fifo_level;

  video_frame_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .FIFO_DEPTH(FD)) dut (
    .clk_rd(clk_rd), .rst(rst), .capture_en(capture_en), .ping_pong_en(ping_pong_en),
    .wr_addr_min(wr_addr_min), .wr_addr_max(wr_addr_max), .br_length(br_length),
    .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .BLANK(BLANK), .display_data(display_data),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_addr(wr_addr), .wr_len(wr_len),
    .wr_bank(wr_bank), .wr_data(wr_data), .wr_data_rd(wr_data_rd),
    .frame_done(frame_done), .overflow(overflow), .fmt_err(fmt_err),
    .fifo_level(fifo_level)
  );

  always #5 clk_rd = ~clk_rd;

  int n_pass = 0;
  int n_total = 0;
  logic ack_en = 1'b1;
  int remaining = 0;
  int done_cnt = 0;
  logic [23:0] b_addr[$];
  logic [9:0]  b_len[$];
  logic        b_bank[$];
  logic [15:0] dq[$];

  // Downstream SDRAM write port: grants each request, then pops wr_len words.
  initial begin
    wr_ack = 1'b0;
    wr_data_rd = 1'b0;
    forever begin
      @(negedge clk_rd);
      wr_ack = 1'b0;
      wr_data_rd = 1'b0;
      if (rst) begin
        remaining = 0;
      end else begin
        if (frame_done) done_cnt++;
        if (remaining > 0) begin
          dq.push_back(wr_data);
          wr_data_rd = 1'b1;
          remaining--;
        end else if (wr_req && ack_en) begin
          b_addr.push_back(wr_addr);
          b_len.push_back(wr_len);
          b_bank.push_back(wr_bank);
          wr_ack = 1'b1;
          remaining = int'(wr_len);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_rd);
    rst = 1'b1;
    repeat (2) @(negedge clk_rd);
    b_addr.delete(); b_len.delete(); b_bank.delete(); dq.delete();
    done_cnt = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk_rd);
  endtask

  task automatic send_frame(input int short_line);
    int v;
    v = 0;
    @(negedge clk_rd);
    V_SYNC = 1'b1;
    repeat (2) @(negedge clk_rd);
    for (int l = 0; l < VA; l++) begin
      for (int p = 0; p < ((l == short_line) ? HA - 1 : HA); p++) begin
        BLANK = 1'b1;
        display_data = 16'(v);
        v++;
        @(negedge clk_rd);
      end
      BLANK = 1'b0;
      repeat (3) @(negedge clk_rd);
    end
    V_SYNC = 1'b0;
    repeat (2) @(negedge clk_rd);
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_cnt < 1 && t < 3000) begin
      @(negedge clk_rd);
      t++;
    end
    repeat (6) @(negedge clk_rd);
    n_total++;
    if (done_cnt !== 1) $display("FAIL %s frame_done pulses got %0d want 1", name, done_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    wr_addr_min = 24'h000100;
    rst = 1'b1;
    repeat (3) @(negedge clk_rd);
    n_total++;
    if ({wr_req, wr_bank, frame_done, overflow, fmt_err} !== 5'b0)
      $display("FAIL reset_flags got %b want 00000", {wr_req, wr_bank, frame_done, overflow, fmt_err});
    else n_pass++;
    n_total++;
    if (fifo_level !== 11'd0) $display("FAIL reset_level got %0d want 0", fifo_level);
    else n_pass++;
    n_total++;
    if (wr_addr !== 24'd0 || wr_len !== 10'd0 || wr_data !== 16'd0)
      $display("FAIL reset_desc got %0d/%0d/%0d want 0/0/0", wr_addr, wr_len, wr_data);
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk_rd);
    n_total++;
    if (wr_addr !== 24'h000100) $display("FAIL reset_ptr_load got %h want 000100", wr_addr);
    else n_pass++;
    wr_addr_min = 24'd0;
  endtask

  task automatic test_single_frame();
    logic [23:0] ea [4] = '{0, 8, 16, 24};
    logic any_bank;
    do_reset();
    send_frame(-1);
    wait_done("t1");
    n_total++;
    if (b_addr.size() !== 4) $display("FAIL t1_burst_count got %0d want 4", b_addr.size());
    else n_pass++;
    for (int i = 0; i < b_addr.size() && i < 4; i++) begin
      n_total++;
      if (b_addr[i] !== ea[i] || b_len[i] !== 10'd8)
        $display("FAIL t1_burst%0d got %0d/%0d want %0d/8", i, b_addr[i], b_len[i], ea[i]);
      else n_pass++;
    end
    n_total++;
    if (dq.size() !== 32) $display("FAIL t1_word_count got %0d want 32", dq.size());
    else n_pass++;
    for (int i = 0; i < dq.size(); i++) begin
      n_total++;
      if (dq[i] !== 16'(i)) $display("FAIL t1_data%0d got %0d want %0d", i, dq[i], i);
      else n_pass++;
    end
    any_bank = 1'b0;
    foreach (b_bank[i]) any_bank = any_bank | b_bank[i];
    n_total++;
    if (any_bank !== 1'b0 || wr_bank !== 1'b1)
      $display("FAIL t1_bank got burst %b final %b want 0 1", any_bank, wr_bank);
    else n_pass++;
    n_total++;
    if (fmt_err !== 1'b0 || overflow !== 1'b0)
      $display("FAIL t1_errors got fmt %b ovf %b want 0 0", fmt_err, overflow);
    else n_pass++;
  endtask

  task automatic test_long_burst();
    logic [23:0] ea [3] = '{0, 12, 24};
    logic [9:0]  el [3] = '{12, 12, 8};
    do_reset();
    br_length = 10'd12;
    send_frame(-1);
    wait_done("t2");
    n_total++;
    if (b_addr.size() !== 3) $display("FAIL t2_burst_count got %0d want 3", b_addr.size());
    else n_pass++;
    for (int i = 0; i < b_addr.size() && i < 3; i++) begin
      n_total++;
      if (b_addr[i] !== ea[i] || b_len[i] !== el[i])
        $display("FAIL t2_burst%0d got %0d/%0d want %0d/%0d", i, b_addr[i], b_len[i], ea[i], el[i]);
      else n_pass++;
    end
    n_total++;
    if (dq.size() !== 32 || dq[dq.size()-1] !== 16'd31)
      $display("FAIL t2_last_word got count %0d want 32 ending in 31", dq.size());
    else n_pass++;
    br_length = 10'd8;
  endtask

  task automatic test_wrap();
    logic [23:0] ea [5] = '{0, 8, 16, 0, 8};
    logic [9:0]  el [5] = '{8, 8, 4, 8, 4};
    do_reset();
    wr_addr_max = 24'd20;
    send_frame(-1);
    wait_done("t3");
    n_total++;
    if (b_addr.size() !== 5) $display("FAIL t3_burst_count got %0d want 5", b_addr.size());
    else n_pass++;
    for (int i = 0; i < b_addr.size() && i < 5; i++) begin
      n_total++;
      if (b_addr[i] !== ea[i] || b_len[i] !== el[i])
        $display("FAIL t3_burst%0d got %0d/%0d want %0d/%0d", i, b_addr[i], b_len[i], ea[i], el[i]);
      else n_pass++;
    end
    for (int i = 0; i < dq.size(); i++) begin
      n_total++;
      if (dq[i] !== 16'(i)) $display("FAIL t3_data%0d got %0d want %0d", i, dq[i], i);
      else n_pass++;
    end
    wr_addr_max = 24'd1000;
  endtask

  task automatic test_overflow();
    do_reset();
    ack_en = 1'b0;
    send_frame(-1);
    n_total++;
    if (overflow !== 1'b1 || fifo_level !== 11'd16)
      $display("FAIL t4_full got ovf %b level %0d want 1 16", overflow, fifo_level);
    else n_pass++;
    n_total++;
    if (wr_req !== 1'b1 || wr_len !== 10'd8)
      $display("FAIL t4_pending_req got req %b len %0d want 1 8", wr_req, wr_len);
    else n_pass++;
    ack_en = 1'b1;
    wait_done("t4");
    n_total++;
    if (b_addr.size() !== 2) $display("FAIL t4_burst_count got %0d want 2", b_addr.size());
    else n_pass++;
    n_total++;
    if (dq.size() !== 16) $display("FAIL t4_word_count got %0d want 16", dq.size());
    else n_pass++;
    for (int i = 0; i < dq.size(); i++) begin
      n_total++;
      if (dq[i] !== 16'(i)) $display("FAIL t4_data%0d got %0d want %0d", i, dq[i], i);
      else n_pass++;
    end
    n_total++;
    if (overflow !== 1'b1) $display("FAIL t4_sticky got %b want 1", overflow);
    else n_pass++;
  endtask

  task automatic test_fmt_err();
    logic [23:0] ea [4] = '{0, 8, 16, 24};
    logic [9:0]  el [4] = '{8, 8, 8, 7};
    do_reset();
    send_frame(1);
    wait_done("t5");
    n_total++;
    if (fmt_err !== 1'b1) $display("FAIL t5_fmt_err got %b want 1", fmt_err);
    else n_pass++;
    n_total++;
    if (dq.size() !== 31) $display("FAIL t5_word_count got %0d want 31", dq.size());
    else n_pass++;
    for (int i = 0; i < b_addr.size() && i < 4; i++) begin
      n_total++;
      if (b_addr[i] !== ea[i] || b_len[i] !== el[i])
        $display("FAIL t5_burst%0d got %0d/%0d want %0d/%0d", i, b_addr[i], b_len[i], ea[i], el[i]);
      else n_pass++;
    end
    repeat (10) @(negedge clk_rd);
    n_total++;
    if (fmt_err !== 1'b1) $display("FAIL t5_fmt_sticky got %b want 1", fmt_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int t;
    logic any_bank;
    do_reset();
    send_frame(-1);
    wait_done("t6a");
    n_total++;
    if (wr_bank !== 1'b1) $display("FAIL t6_bank_before got %b want 1", wr_bank);
    else n_pass++;
    b_addr.delete(); b_len.delete(); b_bank.delete(); dq.delete();
    ack_en = 1'b0;
    send_frame(-1);
    ack_en = 1'b1;
    t = 0;
    while (!(b_addr.size() == 2 && remaining > 0 && remaining < 8) && t < 500) begin
      @(negedge clk_rd);
      #1;
      t++;
    end
    n_total++;
    if (t >= 500) $display("FAIL t6_reach_xfer got timeout want second burst in flight");
    else n_pass++;
    rst = 1'b1;
    #1;
    n_total++;
    if (wr_req !== 1'b0 || fifo_level !== 11'd0 || wr_bank !== 1'b0)
      $display("FAIL t6_async_reset got req %b level %0d bank %b want 0 0 0", wr_req, fifo_level, wr_bank);
    else n_pass++;
    repeat (2) @(negedge clk_rd);
    b_addr.delete(); b_len.delete(); b_bank.delete(); dq.delete();
    done_cnt = 0;
    ping_pong_en = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk_rd);
    send_frame(-1);
    wait_done("t6b");
    n_total++;
    if (b_addr.size() !== 4 || b_addr[0] !== 24'd0)
      $display("FAIL t6_restart got %0d bursts first addr %0d want 4 at 0", b_addr.size(), b_addr[0]);
    else n_pass++;
    any_bank = 1'b0;
    foreach (b_bank[i]) any_bank = any_bank | b_bank[i];
    n_total++;
    if (any_bank !== 1'b0 || wr_bank !== 1'b0)
      $display("FAIL t6_bank_hold got burst %b final %b want 0 0", any_bank, wr_bank);
    else n_pass++;
    n_total++;
    if (dq.size() !== 32 || dq[0] !== 16'd0 || dq[31] !== 16'd31)
      $display("FAIL t6_data got count %0d want 32 words 0..31", dq.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_long_burst();
    test_wrap();
    test_overflow();
    test_fmt_err();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_frame_capture.md
Name: video_frame_capture

Overview:
- Receive-side counterpart of the display timing output. Consumes an H_SYNC/V_SYNC/BLANK/16-bit pixel stream, such as the ISP display output or an RGB2YUV stage output.
- Buffers active pixels in an internal FIFO and issues length-tagged write bursts to the SDRAM write port.
- Each burst targets a ping-pong frame region bounded by wr_addr_min/wr_addr_max.
- Used for loopback capture of processed frames back into SDRAM.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
FIFO_DEPTH, 1024, pixel FIFO depth (power of two, at least the largest br_length)

Ports:
clk_rd  in  1  pixel/system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
capture_en  in  1  arms capture at the next frame start
ping_pong_en  in  1  toggle wr_bank after each completed frame
wr_addr_min  in  24  first word address of frame region
wr_addr_max  in  24  end of region (exclusive)
br_length  in  10  maximum burst length in words; 0 is treated as 1
H_SYNC  in  1  line sync (informational, unused for counting)
V_SYNC  in  1  high for the duration of a frame
BLANK  in  1  high = display_data valid (active pixel)
display_data  in  16  pixel
wr_req  out  1  burst request
wr_ack  in  1  one-cycle burst grant
wr_addr  out  24  burst start address
wr_len  out  10  burst length in words
wr_bank  out  1  ping-pong buffer select
wr_data  out  16  FIFO head (show-ahead)
wr_data_rd  in  1  downstream pops wr_data
frame_done  out  1  one-cycle pulse when last word of frame is transferred
overflow  out  1  sticky: pixel dropped due to full FIFO
fmt_err  out  1  sticky: line or frame size mismatch
fifo_level  out  11  current FIFO occupancy

Behaviour:
Reset values:
- All outputs are 0. FIFO is empty. Address pointer = wr_addr_min (sampled on the first cycle after reset). Counters are 0. FSM = IDLE.
- Reset mid-burst: wr_req drops asynchronously. The partial burst is abandoned and never resumed.

Input path:
- V_SYNC, BLANK and display_data are registered once. A pixel valid at cycle n is written to the FIFO at n+1.
- Frame start = registered V_SYNC rising edge. If capture_en=1 and flush_pending=0, set capturing=1, x=y=0, address pointer = wr_addr_min. Otherwise the frame is ignored entirely.
- While capturing and BLANK=1: push the pixel and increment x. If the FIFO is full, drop the pixel and set overflow.
- BLANK falling edge while capturing: if x!=H_ACTIVE, set fmt_err. Then x=0 and y++.
- V_SYNC falling edge while capturing: if y!=V_ACTIVE, set fmt_err. Then capturing=0 and flush_pending=1.
- A push and a pop in the same cycle are both allowed; fifo_level is unchanged.

Burst FSM (states IDLE, REQ, XFER):
- IDLE, fifo_level >= L (L = max(br_length,1)): go to REQ. wr_len = min(L, wr_addr_max - ptr).
- IDLE, flush_pending=1 and 0 < fifo_level < L: go to REQ. wr_len = min(fifo_level, wr_addr_max - ptr).
- IDLE, flush_pending=1 and fifo_level=0 (no pop outstanding): pulse frame_done, clear flush_pending. If ping_pong_en=1, toggle wr_bank.
- REQ: hold wr_req=1 with wr_addr=ptr, wr_len and wr_bank stable until wr_ack. On wr_ack go to XFER; wr_req is low from the next cycle.
- XFER: each wr_data_rd pops one word (gaps allowed). After wr_len pops, go to IDLE and set ptr += wr_len. If ptr reaches wr_addr_max, wrap to wr_addr_min.
- Bursts never cross wr_addr_max.
- wr_data_rd outside XFER, or beyond wr_len, is ignored.
- wr_ack outside REQ is ignored.

Test Plan:
Common setup unless stated: H_ACTIVE=8, V_ACTIVE=4, FIFO_DEPTH=16, br_length=8, min=0, max=1000, capture_en=1, ping_pong_en=1; downstream acks and pops continuously.
1. One 8x4 frame, pixels 0..31 -> bursts addr/len 0/8, 8/8, 16/8, 24/8; wr_data 0..31 in order; one frame_done pulse; wr_bank 0->1; fmt_err=0.
2. br_length=12, same frame -> bursts 0/12, 12/12, 24/8 (flush); frame_done after word 31.
3. max=20, br_length=8 -> bursts 0/8, 8/8, 16/4, 0/8, 8/4; data continuous 0..31.
4. wr_ack held 0, one frame -> overflow=1 from the 17th pixel; fifo_level=16. Then ack -> two bursts carry data 0..15 and frame_done fires.
5. Line 2 has 7 active pixels -> fmt_err=1 and stays 1. Frame still flushes with 31 words.
6. Assert rst during XFER of burst 2 -> same cycle: wr_req=0, fifo_level=0, wr_bank=0. Next frame with ping_pong_en=0 restarts at addr 0 and wr_bank stays 0.
